stopwatch_core: RTL and testbench

- Timekeeping stage of the simple-clock stopwatch, directly upstream of the SPI display driver.
- Divides the system clock into a 100 Hz centisecond tick and keeps a cascaded BCD time count of MM:SS.CC.
- Implements start/stop and lap/reset control, and presents the six BCD digit buses plus an update strobe that the driver consumes.

---
 rtl/stopwatch_core.sv | 180 ++++++++++++++++++
 tb/tb_stopwatch_core.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_core.sv
// rtl/stopwatch_core.sv - centisecond prescaler, MM:SS.CC BCD count and start/stop, lap/reset control
// Display register feeds the SPI display driver; update pulses when any shown digit changes.
module stopwatch_core #(
  parameter int TICK_DIV = 10000
) (
  input  logic       clk,
  input  logic       res,
  input  logic       ena,
  input  logic       btn_start_stop,
  input  logic       btn_lap_reset,
  output logic [2:0] min_X0,
  output logic [3:0] min_0X,
  output logic [2:0] sec_X0,
  output logic [3:0] sec_0X,
  output logic [3:0] ces_X0,
  output logic [3:0] ces_0X,
  output logic       update,
  output logic       wrapped
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_TOP = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUNNING = 2'd1,
    S_LAP     = 2'd2,
    S_PAUSED  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;

  logic r_ss_s1, r_ss_s2, r_ss_d;
  logic r_lr_s1, r_lr_s2, r_lr_d;
  logic w_ss_pulse, w_lr_pulse;

  logic [PW-1:0] r_presc;
  logic [2:0]    r_min_x0;
  logic [3:0]    r_min_0x;
  logic [2:0]    r_sec_x0;
  logic [3:0]    r_sec_0x;
  logic [3:0]    r_ces_x0;
  logic [3:0]    r_ces_0x;
  logic          r_wrapped;
  logic [21:0]   r_disp;
  logic          r_update;

  logic        w_counting, w_tick, w_clear, w_disp_load;
  logic        w_c0, w_c1, w_c2, w_c3, w_c4, w_c5;
  logic [21:0] w_cnt;

  assign w_ss_pulse = r_ss_s2 & ~r_ss_d;
  assign w_lr_pulse = r_lr_s2 & ~r_lr_d;

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_ss_s1 <= 1'b0;
      r_ss_s2 <= 1'b0;
      r_ss_d  <= 1'b0;
      r_lr_s1 <= 1'b0;
      r_lr_s2 <= 1'b0;
      r_lr_d  <= 1'b0;
    end else if (ena) begin
      r_ss_s1 <= btn_start_stop;
      r_ss_s2 <= r_ss_s1;
      r_ss_d  <= r_ss_s2;
      r_lr_s1 <= btn_lap_reset;
      r_lr_s2 <= r_lr_s1;
      r_lr_d  <= r_lr_s2;
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_state <= S_IDLE;
    end else if (ena) begin
      r_state <= w_next;
    end
  end

  // start_stop has priority: a coincident lap_reset pulse is simply dropped
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_ss_pulse) w_next = S_RUNNING;
      end
      S_RUNNING: begin
        if (w_ss_pulse)      w_next = S_PAUSED;
        else if (w_lr_pulse) w_next = S_LAP;
      end
      S_LAP: begin
        if (w_ss_pulse)      w_next = S_PAUSED;
        else if (w_lr_pulse) w_next = S_RUNNING;
      end
      S_PAUSED: begin
        if (w_ss_pulse)      w_next = S_RUNNING;
        else if (w_lr_pulse) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign w_counting = (r_state == S_RUNNING) || (r_state == S_LAP);
  assign w_tick     = w_counting && (r_presc == PRESC_TOP);
  assign w_clear    = (r_state == S_PAUSED) && !w_ss_pulse && w_lr_pulse;

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_presc <= '0;
    end else if (ena) begin
      if (w_clear || r_state == S_IDLE) r_presc <= '0;
      else if (w_tick)                  r_presc <= '0;
      else if (w_counting)              r_presc <= r_presc + 1'b1;
    end
  end

  assign w_c0 = (r_ces_0x == 4'd9);
  assign w_c1 = w_c0 && (r_ces_x0 == 4'd9);
  assign w_c2 = w_c1 && (r_sec_0x == 4'd9);
  assign w_c3 = w_c2 && (r_sec_x0 == 3'd5);
  assign w_c4 = w_c3 && (r_min_0x == 4'd9);
  assign w_c5 = w_c4 && (r_min_x0 == 3'd5);

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_min_x0  <= '0;
      r_min_0x  <= '0;
      r_sec_x0  <= '0;
      r_sec_0x  <= '0;
      r_ces_x0  <= '0;
      r_ces_0x  <= '0;
      r_wrapped <= 1'b0;
    end else if (ena) begin
      if (w_clear) begin
        r_min_x0  <= '0;
        r_min_0x  <= '0;
        r_sec_x0  <= '0;
        r_sec_0x  <= '0;
        r_ces_x0  <= '0;
        r_ces_0x  <= '0;
        r_wrapped <= 1'b0;
      end else if (w_tick) begin
        r_ces_0x <= w_c0 ? 4'd0 : r_ces_0x + 4'd1;
        if (w_c0) r_ces_x0 <= w_c1 ? 4'd0 : r_ces_x0 + 4'd1;
        if (w_c1) r_sec_0x <= w_c2 ? 4'd0 : r_sec_0x + 4'd1;
        if (w_c2) r_sec_x0 <= w_c3 ? 3'd0 : r_sec_x0 + 3'd1;
        if (w_c3) r_min_0x <= w_c4 ? 4'd0 : r_min_0x + 4'd1;
        if (w_c4) r_min_x0 <= w_c5 ? 3'd0 : r_min_x0 + 3'd1;
        if (w_c5) r_wrapped <= 1'b1;
      end
    end
  end

  assign w_cnt = {r_min_x0, r_min_0x, r_sec_x0, r_sec_0x, r_ces_x0, r_ces_0x};

  // The display holds only while staying in LAP; the RUNNING->LAP edge itself is the capture
  assign w_disp_load = (r_state != S_LAP) || (w_next != S_LAP);

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_disp   <= '0;
      r_update <= 1'b0;
    end else if (ena) begin
      r_update <= w_disp_load && (w_cnt != r_disp);
      if (w_disp_load) r_disp <= w_cnt;
    end
  end

  assign min_X0  = r_disp[21:19];
  assign min_0X  = r_disp[18:15];
  assign sec_X0  = r_disp[14:12];
  assign sec_0X  = r_disp[11:8];
  assign ces_X0  = r_disp[7:4];
  assign ces_0X  = r_disp[3:0];
  assign update  = r_update & ena;
  assign wrapped = r_wrapped;

endmodule

// File: tb/tb_stopwatch_core.sv
// tb/tb_stopwatch_core.sv - directed self-checking bench for stopwatch_core with TICK_DIV=4
module tb_stopwatch_core;

  logic       clk;
  logic       res;
  logic       ena;
  logic       btn_ss;
  logic       btn_lr;
  logic [2:0] min_X0;
  logic [3:0] min_0X;
  logic [2:0] sec_X0;
  logic [3:0] sec_0X;
  logic [3:0] ces_X0;
  logic [3:0] ces_0X;
  logic       update;
  logic       wrapped;

  int n_tests = 0;
  int n_fail  = 0;

  logic [21:0] w_disp;
  assign w_disp = {min_X0, min_0X, sec_X0, sec_0X, ces_X0, ces_0X};

  stopwatch_core #(.TICK_DIV(4)) dut (
    .clk            (clk),
    .res            (res),
    .ena            (ena),
    .btn_start_stop (btn_ss),
    .btn_lap_reset  (btn_lr),
    .min_X0         (min_X0),
    .min_0X         (min_0X),
    .sec_X0         (sec_X0),
    .sec_0X         (sec_0X),
    .ces_X0         (ces_X0),
    .ces_0X         (ces_0X),
    .update         (update),
    .wrapped        (wrapped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [21:0] t(input int m1, input int m0, input int s1,
                                    input int s0, input int c1, input int c0);
    return {3'(m1), 4'(m0), 3'(s1), 4'(s0), 4'(c1), 4'(c0)};
  endfunction

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    res = 1'b0;
    btn_ss = 1'b0;
    btn_lr = 1'b0;
    ena = 1'b1;
    cyc(2);
    res = 1'b1;
    cyc(1);
  endtask

  // Returns just after the edge on which the FSM acts on the press
  task automatic press_ss();
    btn_ss = 1'b1;
    cyc(3);
    btn_ss = 1'b0;
  endtask

  task automatic press_lr();
    btn_lr = 1'b1;
    cyc(3);
    btn_lr = 1'b0;
  endtask

  task automatic test_reset();
    res = 1'b0;
    ena = 1'b1;
    btn_ss = 1'b0;
    btn_lr = 1'b0;
    cyc(2);
    n_tests++;
    if (w_disp !== 22'd0) begin
      n_fail++;
      $display("FAIL reset_digits got %h want %h", w_disp, 22'd0);
    end
    n_tests++;
    if (update !== 1'b0 || wrapped !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags got upd=%b wrap=%b want 0 0", update, wrapped);
    end
    res = 1'b1;
    cyc(1);
  endtask

  task automatic test_basic();
    int nupd;
    nupd = 0;
    do_reset();
    press_ss();
    for (int j = 1; j <= 1601; j++) begin
      cyc(1);
      if (update === 1'b1) nupd++;
      if (j == 4) begin
        n_tests++;
        if (w_disp !== t(0,0,0,0,0,0)) begin
          n_fail++;
          $display("FAIL first_tick_early got %h want %h", w_disp, t(0,0,0,0,0,0));
        end
      end
      if (j == 5) begin
        n_tests++;
        if (w_disp !== t(0,0,0,0,0,1)) begin
          n_fail++;
          $display("FAIL first_tick got %h want %h", w_disp, t(0,0,0,0,0,1));
        end
      end
    end
    n_tests++;
    if (w_disp !== t(0,0,0,4,0,0)) begin
      n_fail++;
      $display("FAIL count_400 got %h want %h", w_disp, t(0,0,0,4,0,0));
    end
    n_tests++;
    if (nupd !== 400) begin
      n_fail++;
      $display("FAIL update_per_tick got %0d want 400", nupd);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    press_ss();
    cyc(3);
    press_ss();
    force dut.r_min_x0 = 3'd5;
    force dut.r_min_0x = 4'd9;
    force dut.r_sec_x0 = 3'd5;
    force dut.r_sec_0x = 4'd9;
    force dut.r_ces_x0 = 4'd9;
    force dut.r_ces_0x = 4'd8;
    cyc(1);
    release dut.r_min_x0;
    release dut.r_min_0x;
    release dut.r_sec_x0;
    release dut.r_sec_0x;
    release dut.r_ces_x0;
    release dut.r_ces_0x;
    n_tests++;
    if (w_disp !== t(5,9,5,9,9,8) || update !== 1'b1) begin
      n_fail++;
      $display("FAIL preload got %h upd=%b want %h upd=1", w_disp, update, t(5,9,5,9,9,8));
    end
    cyc(2);
    press_ss();
    cyc(3);
    n_tests++;
    if (w_disp !== t(5,9,5,9,9,9) || wrapped !== 1'b0) begin
      n_fail++;
      $display("FAIL pre_wrap got %h wrap=%b want %h wrap=0", w_disp, wrapped, t(5,9,5,9,9,9));
    end
    cyc(4);
    n_tests++;
    if (w_disp !== t(0,0,0,0,0,0) || wrapped !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap got %h wrap=%b want %h wrap=1", w_disp, wrapped, t(0,0,0,0,0,0));
    end
    cyc(4);
    n_tests++;
    if (w_disp !== t(0,0,0,0,0,1) || wrapped !== 1'b1) begin
      n_fail++;
      $display("FAIL post_wrap got %h wrap=%b want %h wrap=1", w_disp, wrapped, t(0,0,0,0,0,1));
    end
    cyc(3);
    press_ss();
    press_lr();
    n_tests++;
    if (wrapped !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_clear got %b want 0", wrapped);
    end
    cyc(1);
    n_tests++;
    if (w_disp !== 22'd0) begin
      n_fail++;
      $display("FAIL wrap_clear_digits got %h want 0", w_disp);
    end
  endtask

  task automatic test_lap();
    bit bad;
    bad = 1'b0;
    do_reset();
    press_ss();
    cyc(491);
    press_lr();
    n_tests++;
    if (w_disp !== t(0,0,0,1,2,3) || update !== 1'b0) begin
      n_fail++;
      $display("FAIL lap_capture got %h upd=%b want %h upd=0", w_disp, update, t(0,0,0,1,2,3));
    end
    for (int j = 0; j < 197; j++) begin
      cyc(1);
      if (w_disp !== t(0,0,0,1,2,3) || update !== 1'b0) bad = 1'b1;
    end
    n_tests++;
    if (bad) begin
      n_fail++;
      $display("FAIL lap_hold got %h want %h with no update", w_disp, t(0,0,0,1,2,3));
    end
    press_lr();
    n_tests++;
    if (w_disp !== t(0,0,0,1,7,3) || update !== 1'b1) begin
      n_fail++;
      $display("FAIL lap_release got %h upd=%b want %h upd=1", w_disp, update, t(0,0,0,1,7,3));
    end
    bad = 1'b0;
    for (int j = 0; j < 2; j++) begin
      cyc(1);
      if (update !== 1'b0) bad = 1'b1;
    end
    n_tests++;
    if (bad) begin
      n_fail++;
      $display("FAIL lap_release_single got extra update want none");
    end
    cyc(1);
    n_tests++;
    if (w_disp !== t(0,0,0,1,7,4)) begin
      n_fail++;
      $display("FAIL lap_live got %h want %h", w_disp, t(0,0,0,1,7,4));
    end
  endtask

  task automatic test_pause();
    bit bad;
    bad = 1'b0;
    do_reset();
    press_ss();
    cyc(3);
    press_ss();
    for (int j = 0; j < 20; j++) begin
      cyc(1);
      if (w_disp !== t(0,0,0,0,0,1) || update !== 1'b0) bad = 1'b1;
    end
    n_tests++;
    if (bad) begin
      n_fail++;
      $display("FAIL pause_freeze got %h want %h with no update", w_disp, t(0,0,0,0,0,1));
    end
    press_ss();
    cyc(2);
    n_tests++;
    if (w_disp !== t(0,0,0,0,0,1)) begin
      n_fail++;
      $display("FAIL resume_early got %h want %h", w_disp, t(0,0,0,0,0,1));
    end
    cyc(1);
    n_tests++;
    if (w_disp !== t(0,0,0,0,0,2) || update !== 1'b1) begin
      n_fail++;
      $display("FAIL resume_tick got %h upd=%b want %h upd=1", w_disp, update, t(0,0,0,0,0,2));
    end
    cyc(3);
    press_ss();
    press_lr();
    cyc(1);
    n_tests++;
    if (w_disp !== 22'd0 || update !== 1'b1 || wrapped !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_clear got %h upd=%b wrap=%b want 0 1 0", w_disp, update, wrapped);
    end
    bad = 1'b0;
    for (int j = 0; j < 20; j++) begin
      cyc(1);
      if (w_disp !== 22'd0 || update !== 1'b0) bad = 1'b1;
    end
    n_tests++;
    if (bad) begin
      n_fail++;
      $display("FAIL idle_hold got %h want 0 with no update", w_disp);
    end
  endtask

  task automatic test_simultaneous();
    bit bad;
    bad = 1'b0;
    do_reset();
    press_ss();
    cyc(3);
    btn_ss = 1'b1;
    btn_lr = 1'b1;
    cyc(3);
    btn_ss = 1'b0;
    btn_lr = 1'b0;
    for (int j = 0; j < 20; j++) begin
      cyc(1);
      if (w_disp !== t(0,0,0,0,0,1) || update !== 1'b0) bad = 1'b1;
    end
    n_tests++;
    if (bad) begin
      n_fail++;
      $display("FAIL simul_paused got %h want %h with no update", w_disp, t(0,0,0,0,0,1));
    end
    press_ss();
    cyc(3);
    n_tests++;
    if (w_disp !== t(0,0,0,0,0,2)) begin
      n_fail++;
      $display("FAIL simul_resume got %h want %h", w_disp, t(0,0,0,0,0,2));
    end
  endtask

  task automatic test_ena_and_async_reset();
    bit bad;
    bad = 1'b0;
    do_reset();
    press_ss();
    cyc(5);
    ena = 1'b0;
    #1;
    n_tests++;
    if (update !== 1'b0) begin
      n_fail++;
      $display("FAIL ena_update got %b want 0", update);
    end
    for (int j = 0; j < 100; j++) begin
      cyc(1);
      if (j == 10) btn_ss = 1'b1;
      if (j == 50) btn_ss = 1'b0;
      if (w_disp !== t(0,0,0,0,0,1) || update !== 1'b0) bad = 1'b1;
    end
    n_tests++;
    if (bad) begin
      n_fail++;
      $display("FAIL ena_freeze got %h want %h with no update", w_disp, t(0,0,0,0,0,1));
    end
    ena = 1'b1;
    cyc(3);
    n_tests++;
    if (w_disp !== t(0,0,0,0,0,1)) begin
      n_fail++;
      $display("FAIL ena_presc_held got %h want %h", w_disp, t(0,0,0,0,0,1));
    end
    cyc(1);
    n_tests++;
    if (w_disp !== t(0,0,0,0,0,2) || update !== 1'b1) begin
      n_fail++;
      $display("FAIL ena_resume got %h upd=%b want %h upd=1", w_disp, update, t(0,0,0,0,0,2));
    end
    cyc(3);
    res = 1'b0;
    #2;
    n_tests++;
    if (w_disp !== 22'd0 || update !== 1'b0 || wrapped !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset got %h upd=%b wrap=%b want 0 0 0", w_disp, update, wrapped);
    end
    cyc(1);
    res = 1'b1;
  endtask

  initial begin
    res = 1'b0;
    ena = 1'b1;
    btn_ss = 1'b0;
    btn_lr = 1'b0;
    test_reset();
    test_basic();
    test_wrap();
    test_lap();
    test_pause();
    test_simultaneous();
    test_ena_and_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
